// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 (modified Booth) multiplier, WIDTH/2+1 steps per product, start/busy/done handshake.
// Optional macro BOOTH_MAC_EN adds acc_en: the finished product is added into result instead of replacing it.
module booth_r4_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
`ifdef BOOTH_MAC_EN
    input  logic                 acc_en,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int AW = 2*WIDTH + 4;
    localparam int MW = WIDTH + 2;
    localparam int N  = WIDTH/2 + 1;
    localparam int CW = $clog2(N + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_seq_mul: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t                state, state_nxt;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  mcand;
    logic [MW-1:0]         mplr;
    logic                  mprev;
    logic [CW-1:0]         cnt;
    logic                  accept;
    logic                  last;
    logic [2*WIDTH-1:0]    prod;
`ifdef BOOTH_MAC_EN
    logic                  mac_q;
`endif

    // Booth-4 digit selection; the caller supplies the multiplicand already scaled by 4^i
    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                      input logic signed [AW-1:0] m);
        case (trip)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m <<< 1;
            3'b100:         booth_pp = -(m <<< 1);
            3'b101, 3'b110: booth_pp = -m;
            default:        booth_pp = '0;
        endcase
    endfunction

    assign accept = start && (state != CALC);
    assign last   = (state == CALC) && (cnt == '0);
    assign prod   = acc[2*WIDTH-1:0];
    assign busy   = (state == CALC);
    assign done   = (state == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FINISH;
            FINISH:  state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplicand shifts left by two and multiplier right by two each step, so the
    // current triplet is always {mplr[1:0], mprev}; the cnt==0 cycle only hands off to FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            mprev <= 1'b0;
            cnt   <= '0;
`ifdef BOOTH_MAC_EN
            mac_q <= 1'b0;
`endif
        end else if (accept) begin
            acc   <= '0;
            mcand <= signed_mode ? {{(AW-WIDTH){x[WIDTH-1]}}, x} : {{(AW-WIDTH){1'b0}}, x};
            mplr  <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
            mprev <= 1'b0;
            cnt   <= CW'(N);
`ifdef BOOTH_MAC_EN
            mac_q <= acc_en;
`endif
        end else if (state == CALC && cnt != '0) begin
            acc   <= acc + booth_pp({mplr[1:0], mprev}, mcand);
            mcand <= mcand <<< 2;
            mprev <= mplr[1];
            mplr  <= mplr >> 2;
            cnt   <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (last) begin
`ifdef BOOTH_MAC_EN
            result <= mac_q ? result + prod : prod;
`else
            result <= prod;
`endif
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Bench for booth_r4_seq_mul: a WIDTH=4 and a WIDTH=8 instance, table vectors plus handshake corner cases.
module tb_booth_r4_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  x4 = '0, m4 = '0;
    logic        busy4, done4;
    logic [7:0]  result4;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  x8 = '0, m8 = '0;
    logic        busy8, done8;
    logic [15:0] result8;
`ifdef BOOTH_MAC_EN
    logic        acc_en4 = 1'b0, acc_en8 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[14];

    always #5 clk = ~clk;

    booth_r4_seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .multiplier(m4), .signed_mode(sm4),
`ifdef BOOTH_MAC_EN
        .acc_en(acc_en4),
`endif
        .busy(busy4), .done(done4), .result(result4));

    booth_r4_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .multiplier(m8), .signed_mode(sm8),
`ifdef BOOTH_MAC_EN
        .acc_en(acc_en8),
`endif
        .busy(busy8), .done(done8), .result(result8));

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
        logic signed [15:0] sa, sb;
        if (sm) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return sa * sb;
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected product
    always @(negedge clk) begin
        if (done4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected got result %h want no done", result4);
            end else if (result4 !== q4[0]) begin
                errors++;
                $display("FAIL result4 got %h want %h", result4, q4[0]);
            end
            if (q4.size() != 0) void'(q4.pop_front());
        end
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected got result %h want no done", result8);
            end else if (result8 !== q8[0]) begin
                errors++;
                $display("FAIL result8 got %h want %h", result8, q8[0]);
            end
            if (q8.size() != 0) void'(q8.pop_front());
        end
    end

    task automatic launch(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp);
        if (w8) begin
            x8 = a; m8 = b; sm8 = sm; start8 = 1'b1;
            q8.push_back(exp);
        end else begin
            x4 = a[3:0]; m4 = b[3:0]; sm4 = sm; start4 = 1'b1;
            q4.push_back(exp[7:0]);
        end
    endtask

    // Called #1 after the accepting edge; lat counts edges after it until done is seen
    task automatic wait_done(input bit w8, input int lat_exp, input int lat0, input string name);
        int   lat;
        logic d;
        lat = lat0;
        do begin
            @(posedge clk); #1;
            lat++;
            d = w8 ? done8 : done4;
        end while (!d && lat < 40);
        checks++;
        if (!d || lat != lat_exp) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d (done=%b)", name, lat, lat_exp, d);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input string name);
        @(negedge clk);
        launch(1'b1, a, b, sm, exp);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(1'b1, 6, 0, name);
    endtask

    initial begin
        tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[1]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[3]  = '{8'h00, 8'h7F, 1'b1, 16'h0000};
        tbl[4]  = '{8'h00, 8'h7F, 1'b0, 16'h0000};
        tbl[5]  = '{8'h7F, 8'h00, 1'b1, 16'h0000};
        tbl[6]  = '{8'hFF, 8'h05, 1'b1, 16'hFFFB};
        tbl[7]  = '{8'h05, 8'hFF, 1'b1, 16'hFFFB};
        tbl[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        tbl[9]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        tbl[10] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
        tbl[11] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        tbl[12] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        tbl[13] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

        // Asynchronous reset state before any clock edge
        #1;
        chk("rst_busy4", {15'd0, busy4}, 16'd0);
        chk("rst_done4", {15'd0, done4}, 16'd0);
        chk("rst_result4", {8'd0, result4}, 16'd0);
        chk("rst_busy8", {15'd0, busy8}, 16'd0);
        chk("rst_done8", {15'd0, done8}, 16'd0);
        chk("rst_result8", result8, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // WIDTH=4: -5 * -7, busy during CALC, done 4 edges after start
        @(negedge clk);
        launch(1'b0, 8'h0B, 8'h09, 1'b1, 16'h0023);
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("w4_busy_after_start", {15'd0, busy4}, 16'd1);
        chk("w4_done_after_start", {15'd0, done4}, 16'd0);
        wait_done(1'b0, 4, 0, "w4_neg5_neg7");
        chk("w4_busy_in_done", {15'd0, busy4}, 16'd0);

        // WIDTH=4 back-to-back: second start raised in the done cycle
        @(negedge clk);
        launch(1'b0, 8'h06, 8'h0D, 1'b1, 16'h00EE);
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done(1'b0, 4, 0, "w4_6_neg3");
        launch(1'b0, 8'h0C, 8'h0F, 1'b1, 16'h0004);
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("w4_b2b_busy", {15'd0, busy4}, 16'd1);
        chk("w4_hold_ee", {8'd0, result4}, 16'h00EE);
        repeat (2) @(posedge clk);
        #1;
        chk("w4_hold_ee_late", {8'd0, result4}, 16'h00EE);
        wait_done(1'b0, 4, 2, "w4_neg4_neg1");

        // WIDTH=8 table vectors, then random vectors against the reference model
        for (int i = 0; i < 14; i++)
            op8(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].exp, $sformatf("tbl%0d", i));
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, b;
            logic       sm;
            a  = 8'($urandom);
            b  = 8'($urandom);
            sm = 1'($urandom_range(0, 1));
            op8(a, b, sm, model(a, b, sm), $sformatf("rnd%0d", i));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("w8_hold_idle", result8, q8.size() == 0 ? model(x8, m8, sm8) : 16'hXXXX);
        chk("w8_idle_done", {15'd0, done8}, 16'd0);

        // start held through CALC with changing operands: only 3*5 completes
        @(negedge clk);
        launch(1'b1, 8'h03, 8'h05, 1'b0, 16'h000F);
        @(posedge clk); #1;
        x8 = 8'h7F; m8 = 8'h7F; sm8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done(1'b1, 6, 4, "w8_held_start");
        @(posedge clk); #1;
        chk("w8_done_one_cycle", {15'd0, done8}, 16'd0);
        chk("w8_idle_after_held", {15'd0, busy8}, 16'd0);
        repeat (10) @(posedge clk);

        // Reset mid-CALC: everything clears at once, no done follows
        @(negedge clk);
        launch(1'b1, 8'h09, 8'h07, 1'b0, 16'h003F);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("w8_busy_before_rst", {15'd0, busy8}, 16'd1);
        rst = 1'b1;
        #1;
        chk("w8_rst_busy", {15'd0, busy8}, 16'd0);
        chk("w8_rst_done", {15'd0, done8}, 16'd0);
        chk("w8_rst_result", result8, 16'd0);
        chk("w4_rst_result", {8'd0, result4}, 16'd0);
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("w8_no_done_after_abort", {15'd0, done8}, 16'd0);
        chk("w8_result_after_abort", result8, 16'd0);

`ifdef BOOTH_MAC_EN
        // Accumulate mode: 12, then +(-10), then +(-3)
        acc_en8 = 1'b0;
        op8(8'h03, 8'h04, 1'b1, 16'h000C, "mac_3x4");
        acc_en8 = 1'b1;
        op8(8'hFE, 8'h05, 1'b1, 16'h0002, "mac_neg2x5");
        op8(8'h01, 8'hFD, 1'b1, 16'hFFFF, "mac_1xneg3");
        acc_en8 = 1'b0;
        repeat (3) @(posedge clk);
`endif

        repeat (3) @(posedge clk);
        chk("w8_queue_drained", 16'(q8.size()), 16'd0);
        chk("w4_queue_drained", 16'(q4.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
